// File: rtl/mem_word_streamer_if.sv
// Memory read port and UART TX byte port of the word streamer.
// master = streamer side, slave = memory / UART side.
interface mem_word_streamer_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output mem_addr, mem_rd, tx_data, tx_valid,
    input  mem_data, tx_ready
  );

  modport slave (
    input  mem_addr, mem_rd, tx_data, tx_valid,
    output mem_data, tx_ready
  );
endinterface

// File: rtl/mem_word_streamer.sv
// Streams word_count 32-bit words from data memory to UART TX, LSB byte first.
// Optional trailing XOR checksum byte when MEM_STREAM_CHECKSUM_EN is defined.
module mem_word_streamer #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  mem_word_streamer_if.master bus,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SEND,
`ifdef MEM_STREAM_CHECKSUM_EN
    SEND_SUM,
`endif
    FIN
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t           state;
  state_t           state_next;
  logic [31:0]      addr;
  logic [31:0]      shreg;
  logic [1:0]       byte_idx;
  logic [3:0]       wait_cnt;
  logic [CNT_W-1:0] remaining;
`ifdef MEM_STREAM_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic       load;
  logic       capture;
  logic       xfer;
  logic       mem_rd;
  logic       tx_valid;
  logic [7:0] tx_data;

  assign bus.mem_addr = addr;
  assign bus.mem_rd   = mem_rd;
  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    xfer       = 1'b0;
    mem_rd     = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = shreg[7:0];
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            load       = 1'b1;
            state_next = REQ;
          end else begin
            state_next = FIN;
          end
        end
      end
      REQ: begin
        mem_rd     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_cnt == LAT_LAST) begin
          capture    = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        if (bus.tx_ready) begin
          xfer = 1'b1;
          if (byte_idx == 2'd3) begin
            if (remaining == CNT_W'(1)) begin
`ifdef MEM_STREAM_CHECKSUM_EN
              state_next = SEND_SUM;
`else
              state_next = FIN;
`endif
            end else begin
              state_next = REQ;
            end
          end
        end
      end
`ifdef MEM_STREAM_CHECKSUM_EN
      SEND_SUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (bus.tx_ready) state_next = FIN;
      end
`endif
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      shreg     <= '0;
      byte_idx  <= '0;
      wait_cnt  <= '0;
      remaining <= '0;
`ifdef MEM_STREAM_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      // Counter restarts from 0 whenever WAIT is entered
      wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : '0;

      if (load) begin
        remaining <= word_count;
        addr      <= '0;
`ifdef MEM_STREAM_CHECKSUM_EN
        csum      <= '0;
`endif
      end

      if (capture) begin
        shreg    <= bus.mem_data;
        byte_idx <= '0;
      end

      if (xfer) begin
        shreg    <= {8'h00, shreg[31:8]};
        byte_idx <= byte_idx + 2'd1;
`ifdef MEM_STREAM_CHECKSUM_EN
        csum     <= csum ^ shreg[7:0];
`endif
        // Address only advances when another word follows, so it holds the last word address at completion
        if (byte_idx == 2'd3) begin
          remaining <= remaining - CNT_W'(1);
          if (remaining != CNT_W'(1)) addr <= addr + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_word_streamer.sv
// Scoreboard bench for mem_word_streamer: directed scenarios plus random dumps.
module tb_mem_word_streamer;
  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned CNT_W   = 16;
`ifdef MEM_STREAM_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] word_count = '0;
  logic             busy;
  logic             done;

  mem_word_streamer_if bus();

  mem_word_streamer #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:63];
  logic [7:0]  exp_q[$];
  logic [31:0] addr_q[$];
  int          done_q[$];
  int          ready_mode = 0;
  logic        hold_ready = 1'b1;

  // Memory model: data appears MEM_LAT cycles after the read strobe, garbage otherwise
  logic        pipe_v [0:MEM_LAT-1];
  logic [31:0] pipe_d [0:MEM_LAT-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MEM_LAT); i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= bus.mem_rd;
      pipe_d[0] <= mem[bus.mem_addr[7:2]];
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end
  assign bus.mem_data = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : 32'hDEADBEEF;

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = ($urandom_range(3) != 0);
        default: bus.tx_ready = hold_ready;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Reference: words from address 0 upward, each emitted LSB byte first, then done
  task automatic expect_dump(input int unsigned n);
    logic [31:0] w;
`ifdef MEM_STREAM_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'h00;
`endif
    for (int unsigned i = 0; i < n; i++) begin
      addr_q.push_back(32'(i * 4));
      w = mem[i[5:0]];
      for (int unsigned b = 0; b < 4; b++) begin
        exp_q.push_back(w[8*b +: 8]);
`ifdef MEM_STREAM_CHECKSUM_EN
        sum = sum ^ w[8*b +: 8];
`endif
      end
    end
`ifdef MEM_STREAM_CHECKSUM_EN
    if (n != 0) exp_q.push_back(sum);
`endif
    done_q.push_back(1);
  endtask

  task automatic launch(input logic [CNT_W-1:0] wc);
    expect_dump(int'(wc));
    @(posedge clk);
    #1 start = 1'b1;
    word_count = wc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == budget) fail_msg("done_timeout", "no done pulse within budget");
    @(negedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT presents a read, a transfer or done
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_done;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (bus.mem_rd) begin
          if (addr_q.size() == 0) fail_msg("mem_rd", "unexpected read strobe");
          else check("mem_rd_addr", bus.mem_addr, addr_q.pop_front());
        end
        if (prev_stall) begin
          check("stall_valid", 32'(bus.tx_valid), 32'd1);
          check("stall_data", 32'(bus.tx_data), 32'(prev_data));
        end
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) fail_msg("tx_byte", "unexpected byte transfer");
          else check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
        if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
        if (done) begin
          if (done_q.size() == 0) fail_msg("done", "unexpected done pulse");
          else void'(done_q.pop_front());
          check("bytes_before_done", 32'(exp_q.size()), 32'd0);
        end
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
        prev_done  = done;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k, rd_n, valid_n, done_k;
    logic found;
    logic [CNT_W-1:0] wc;

    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word, full-rate sink: cycle-exact latency
    mem[0] = 32'h44332211;
    ready_mode = 0;
    expect_dump(1);
    @(posedge clk);
    #1 start = 1'b1;
    word_count = 1;
    first_k = -1; rd_n = 0; valid_n = 0; done_k = -1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (bus.tx_valid && first_k < 0) first_k = k;
      if (bus.tx_valid) valid_n++;
      if (bus.mem_rd) rd_n++;
      if (done && done_k < 0) done_k = k;
    end
    check("first_valid_cycle", 32'(first_k), 32'(2 + MEM_LAT));
    check("mem_rd_cycles", 32'(rd_n), 32'd1);
    check("valid_cycles", 32'(valid_n), 32'(NB));
    check("done_cycle", 32'(done_k), 32'(2 + int'(MEM_LAT) + NB));

    // Multi-word, address holds afterwards
    mem[0] = 32'hA0A1A2A3;
    mem[1] = 32'hB0B1B2B3;
    mem[2] = 32'hC0C1C2C3;
    launch(3);
    wait_done(200);
    check("addr_hold", bus.mem_addr, 32'd8);
    repeat (3) @(negedge clk);
    check("addr_hold_later", bus.mem_addr, 32'd8);

    // Backpressure on byte 0x33
    mem[0] = 32'h44332211;
    ready_mode = 2;
    hold_ready = 1'b1;
    launch(1);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (bus.tx_valid && bus.tx_data == 8'h22) found = 1'b1;
    end
    if (!found) fail_msg("bp_setup", "byte 0x22 never presented");
    hold_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_data", 32'(bus.tx_data), 32'h33);
      check("bp_valid", 32'(bus.tx_valid), 32'd1);
    end
    hold_ready = 1'b1;
    wait_done(50);
    ready_mode = 0;

    // Zero-length dump: done in the cycle after start
    launch(0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    @(negedge clk);

    // Start while busy is ignored
    ready_mode = 1;
    launch(2);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    word_count = 7;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(300);

    // Reset while byte 1 of word 0 is presented
    ready_mode = 0;
    launch(2);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (bus.tx_valid) found = 1'b1;
    end
    if (!found) fail_msg("rst_setup", "first byte never presented");
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mem_addr", bus.mem_addr, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    exp_q.delete();
    addr_q.delete();
    done_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    launch(2);
    wait_done(200);

    // Random dumps with random sink throttling
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      wc = CNT_W'($urandom_range(0, 6));
      ready_mode = int'($urandom_range(0, 1));
      launch(wc);
      if (wc != 0 && $urandom_range(1) == 1) begin
        @(negedge clk);
        if (busy && !done) begin
          @(posedge clk);
          #1 start = 1'b1;
          word_count = CNT_W'($urandom);
          @(posedge clk);
          #1 start = 1'b0;
        end
      end
      wait_done(400);
    end

    repeat (5) @(negedge clk);
    check("bytes_left", 32'(exp_q.size()), 32'd0);
    check("reads_left", 32'(addr_q.size()), 32'd0);
    check("dones_left", 32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_word_streamer.md
Name: mem_word_streamer

Overview:
- Drains a block of 32-bit words from data memory as a byte stream for the UART transmit path.
- It is the outbound counterpart of the inbound byte-to-word packer. Bytes go out LSB first, so a dumped image re-assembles identically on the host.
- Sits between the data memory read port and the UART TX byte interface.
- Started by the debug/upload controller, which waits for done.

Parameters:
- MEM_LAT, 2: read latency in cycles from the mem_rd cycle to valid mem_data. Legal range 1..15.
- CNT_W, 16: width of the word-count input.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin a dump. Sampled only in IDLE.
- word_count, input, CNT_W: number of words to dump. Latched on an accepted start.
- mem_addr, output, 32: byte address of the current word.
- mem_rd, output, 1: one-cycle read strobe.
- mem_data, input, 32: read data, valid MEM_LAT cycles after mem_rd.
- tx_data, output, 8: byte to UART TX.
- tx_valid, output, 1: tx_data is valid.
- tx_ready, input, 1: UART TX accepts the byte this cycle.
- busy, output, 1: dump in progress.
- done, output, 1: one-cycle pulse when a dump completes.

Behaviour:
- Reset values:
  - state IDLE; mem_addr=0, mem_rd=0, tx_data=0, tx_valid=0, busy=0, done=0.
  - Internal shift register, byte index, wait counter and remaining count all cleared.
- States: IDLE, REQ, WAIT, SEND, FIN.
- IDLE:
  - start=1 and word_count!=0: latch the count, mem_addr<=0, go to REQ. busy=1 from the next cycle.
  - start=1 and word_count==0: go to FIN directly. No memory or TX activity.
  - start is ignored in every state except IDLE.
- REQ (1 cycle): mem_rd=1 with the current mem_addr, then go to WAIT.
- WAIT (MEM_LAT cycles):
  - Wait counter runs from 0 to MEM_LAT-1.
  - On the final WAIT cycle, capture mem_data into the 32-bit shift register, byte index<=0, go to SEND.
- SEND:
  - tx_valid=1 and tx_data=shreg[7:0].
  - A transfer occurs on a cycle with tx_valid&&tx_ready. On transfer: shift the register right by 8 and increment the byte index.
  - After the 4th transfer, decrement remaining. If it reaches 0, go to FIN; otherwise mem_addr<=mem_addr+4 and go to REQ.
  - While tx_valid&&!tx_ready, tx_data and tx_valid must hold stable; no other state changes.
  - tx_valid drops to 0 the cycle after the final byte of a word transfers.
- FIN (1 cycle): done=1, busy=0 from the next cycle, return to IDLE.
- Latency:
  - Start sampled in cycle 0.
  - mem_rd in cycle 1; WAIT spans cycles 2..1+MEM_LAT; first tx_valid in cycle 2+MEM_LAT.
  - Per-word overhead between words: 1+MEM_LAT idle TX cycles.
- Arithmetic:
  - mem_addr is modulo 2^32 and wraps silently.
  - mem_addr holds the last word address after completion until the next accepted start.
  - remaining is CNT_W bits. Maximum dump is 2^CNT_W-1 words.
- Reset mid-operation: abort immediately. All outputs return to reset values next cycle, and no done pulse is generated.
- mem_rd is never asserted outside REQ. At most one outstanding read at any time.

Optional Feature:
- Macro: MEM_STREAM_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of every transferred data byte is maintained, cleared on an accepted start.
  - After the last data byte, an extra SEND_SUM phase presents the checksum byte with the same valid/ready rules, then goes to FIN.
  - word_count==0 still goes straight to FIN with no checksum byte.
- Undefined: no checksum register, no SEND_SUM state; behaviour exactly as above.

Test Plan:
- Single word, no backpressure: MEM_LAT=2, word at addr 0 = 0x44332211, tx_ready=1, start with word_count=1.
  - mem_rd for exactly 1 cycle at addr 0.
  - First tx_valid in cycle 4 after start.
  - Bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - done pulses once; busy falls the next cycle.
- Multi-word: word_count=3, words 0xA0A1A2A3 / 0xB0B1B2B3 / 0xC0C1C2C3.
  - mem_rd at addrs 0, 4, 8 in order.
  - 12 bytes out: A3 A2 A1 A0 B3 ... C0.
  - mem_addr holds 8 after done.
- Backpressure: tx_ready=0 for 5 cycles while byte 2 (0x33) is presented.
  - tx_data stays 0x33 and tx_valid stays 1 throughout.
  - Byte order is unchanged; no duplicate or lost bytes.
- Zero-length and ignored start: start with word_count=0.
  - done pulses on the next cycle; no mem_rd, no tx_valid.
  - A start asserted while busy=1 has no effect on the byte stream or the count.
- Reset mid-SEND: assert rst during byte 1 of word 0.
  - Next cycle: tx_valid=0, busy=0, mem_addr=0, and no done pulse.
  - A subsequent start runs cleanly from addr 0.
- MEM_STREAM_CHECKSUM_EN defined: word_count=1, word 0x44332211.
  - 5 bytes out: 11 22 33 44 44.
  - done pulses only after the checksum byte transfers.
